// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry holding register and a small
// CPU read port.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   rx          serial line (idle high, asynchronous to clk)
//   readEnable  CPU read strobe, one cycle per access
//   regSelect   register select: 00 data, 01 status, 10/11 read as zero
//   Data        combinational read data for the selected register
//   rxValid     holding register contains an unread byte
//   busy        a frame is in progress
//
// state | meaning
// IDLE  | waiting for rx_s low (start of a start bit)
// START | counting to mid start bit, then confirming it is still low
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling the stop bit, then delivering the byte or flagging errors

module uart_rx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int DATA_BITS    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       readEnable,
   input  logic [1:0] regSelect,
   output logic [7:0] Data,
   output logic       rxValid,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state, state_next;
   logic                 rx_meta, rx_s;
   logic [CW-1:0]        cnt, cnt_next;
   logic [2:0]           bit_idx, bit_idx_next;
   logic [DATA_BITS-1:0] shift, shift_next;
   logic [DATA_BITS-1:0] rx_data;
   logic                 frame_err, overrun;
   logic                 stop_ok, stop_bad;
   logic                 data_rd, stat_rd;

   assign data_rd = readEnable && (regSelect == 2'b00);
   assign stat_rd = readEnable && (regSelect == 2'b01);
   assign busy    = (state != IDLE);

   // Synchronizer flops reset to the idle line level so reset never looks
   // like a start bit on its own.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_idx <= bit_idx_next;
         shift   <= shift_next;
      end
   end

   always_comb begin
      state_next   = state;
      cnt_next     = cnt + 1'b1;
      bit_idx_next = bit_idx;
      shift_next   = shift;
      stop_ok      = 1'b0;
      stop_bad     = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (!rx_s) state_next = START;
         end
         START: begin
            if (cnt == CNT_HALF) begin
               cnt_next = '0;
               if (!rx_s) begin
                  state_next   = DATA;
                  bit_idx_next = '0;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt == CNT_FULL) begin
               cnt_next              = '0;
               shift_next[bit_idx]   = rx_s;
               bit_idx_next          = bit_idx + 1'b1;
               if (bit_idx == IDX_LAST) state_next = STOP;
            end
         end
         STOP: begin
            if (cnt == CNT_FULL) begin
               cnt_next   = '0;
               state_next = IDLE;
               if (rx_s) stop_ok  = 1'b1;
               else      stop_bad = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A data read on the completion cycle frees the buffer, so the new byte
   // loads instead of counting as an overrun. Flag sets beat status-read clears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_data   <= '0;
         rxValid   <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (stop_ok && (!rxValid || data_rd)) begin
            rx_data <= shift;
            rxValid <= 1'b1;
         end else if (data_rd) begin
            rxValid <= 1'b0;
         end

         if (stop_ok && rxValid && !data_rd) overrun <= 1'b1;
         else if (stat_rd)                   overrun <= 1'b0;

         if (stop_bad)     frame_err <= 1'b1;
         else if (stat_rd) frame_err <= 1'b0;
      end
   end

   always_comb begin
      Data = 8'h00;
      case (regSelect)
         2'b00:   Data = rx_data;
         2'b01:   Data = {5'b0, overrun, frame_err, rxValid};
         default: Data = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
   localparam int CPB = 104;

   logic       clk;
   logic       reset;
   logic       rx;
   logic       readEnable;
   logic [1:0] regSelect;
   logic [7:0] Data;
   logic       rxValid;
   logic       busy;

   uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .readEnable (readEnable),
      .regSelect  (regSelect),
      .Data       (Data),
      .rxValid    (rxValid),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [7:0] rd_exp_q[$];
   string      rd_name_q[$];
   logic [1:0] pr_exp_q[$];   // {busy, rxValid}
   string      pr_name_q[$];
   logic       probe = 1'b0;
   logic       done  = 1'b0;

   // Monitor: every comparison happens here, on the falling edge.
   always @(negedge clk) begin
      if (readEnable) begin
         checks++;
         if (rd_exp_q.size() == 0) begin
            failures++;
            $display("FAIL read_unexpected: Data=%02h with no expected value", Data);
         end else begin
            automatic logic [7:0] e = rd_exp_q.pop_front();
            automatic string      n = rd_name_q.pop_front();
            if (Data !== e) begin
               failures++;
               $display("FAIL %s: Data got %02h expected %02h", n, Data, e);
            end
         end
      end
      if (probe) begin
         checks++;
         if (pr_exp_q.size() == 0) begin
            failures++;
            $display("FAIL probe_unexpected: no expected value");
         end else begin
            automatic logic [1:0] e = pr_exp_q.pop_front();
            automatic string      n = pr_name_q.pop_front();
            if ({busy, rxValid} !== e) begin
               failures++;
               $display("FAIL %s: busy,rxValid got %b%b expected %b%b",
                        n, busy, rxValid, e[1], e[0]);
            end
         end
      end
      if (done) begin
         checks++;
         if (rd_exp_q.size() != 0 || pr_exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d reads and %0d probes left, expected 0",
                     rd_exp_q.size(), pr_exp_q.size());
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [1:0] sel, input logic [7:0] exp, input string name);
      wait_clks(1);
      rd_exp_q.push_back(exp);
      rd_name_q.push_back(name);
      readEnable = 1'b1;
      regSelect  = sel;
      wait_clks(1);
      readEnable = 1'b0;
      regSelect  = 2'b10;
   endtask

   task automatic do_probe(input logic exp_busy, input logic exp_valid, input string name);
      pr_exp_q.push_back({exp_busy, exp_valid});
      pr_name_q.push_back(name);
      probe = 1'b1;
      @(negedge clk);
      #1;
      probe = 1'b0;
   endtask

   // Starts driving immediately (caller sits just after a rising edge).
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      wait_clks(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clks(CPB);
      end
      rx = stop_bit;
      wait_clks(CPB);
      rx = 1'b1;
      wait_clks(CPB);
   endtask

   initial begin
      reset      = 1'b1;
      rx         = 1'b1;
      readEnable = 1'b0;
      regSelect  = 2'b00;
      wait_clks(5);
      reset = 1'b0;
      wait_clks(2);

      do_probe(1'b0, 1'b0, "reset_flags");
      do_read(2'b01, 8'h00, "reset_status");
      do_read(2'b00, 8'h00, "reset_data");
      do_read(2'b10, 8'h00, "reg10_zero");

      // Clean 0x48 with exact completion timing.
      wait_clks(1);
      fork
         send_frame(8'h48, 1'b1);
         begin
            wait_clks(990);
            do_probe(1'b1, 1'b0, "h48_before_valid");
            wait_clks(1);
            do_probe(1'b0, 1'b1, "h48_valid_edge");
         end
      join
      do_read(2'b00, 8'h48, "h48_data");
      do_probe(1'b0, 1'b0, "h48_valid_cleared");
      do_read(2'b01, 8'h00, "h48_status");

      // Start glitch of 20 clocks.
      wait_clks(1);
      fork
         begin
            rx = 1'b0;
            wait_clks(20);
            rx = 1'b1;
         end
         begin
            wait_clks(54);
            do_probe(1'b1, 1'b0, "glitch_busy");
            wait_clks(1);
            do_probe(1'b0, 1'b0, "glitch_idle");
         end
      join
      wait_clks(CPB);
      do_read(2'b01, 8'h00, "glitch_status");

      // Framing error.
      send_frame(8'hA5, 1'b0);
      do_probe(1'b0, 1'b0, "ferr_no_valid");
      do_read(2'b01, 8'h02, "ferr_status");
      do_read(2'b01, 8'h00, "ferr_status_clr");

      // Overrun.
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      do_read(2'b01, 8'h05, "ovr_status");
      do_read(2'b00, 8'h11, "ovr_data_kept");
      do_read(2'b01, 8'h00, "ovr_status_clr");
      send_frame(8'h33, 1'b1);
      do_read(2'b01, 8'h01, "h33_status");
      do_read(2'b00, 8'h33, "h33_data");

      // Data read on the completion cycle of the second byte.
      send_frame(8'h55, 1'b1);
      fork
         send_frame(8'h7E, 1'b1);
         begin
            wait_clks(990);
            rd_exp_q.push_back(8'h55);
            rd_name_q.push_back("same_cycle_old");
            readEnable = 1'b1;
            regSelect  = 2'b00;
            wait_clks(1);
            readEnable = 1'b0;
            regSelect  = 2'b10;
            do_probe(1'b0, 1'b1, "same_cycle_valid");
         end
      join
      do_read(2'b01, 8'h01, "same_cycle_no_ovr");
      do_read(2'b00, 8'h7E, "same_cycle_data");

      // Reset after data bit 3, with an unread byte pending.
      send_frame(8'h5A, 1'b1);
      fork
         send_frame(8'hF0, 1'b1);
         begin
            wait_clks(480);
            reset = 1'b1;
            wait_clks(2);
            do_probe(1'b0, 1'b0, "rst_mid_outputs");
            wait_clks(48);
            reset = 1'b0;
         end
      join
      do_probe(1'b0, 1'b0, "rst_no_valid");
      do_read(2'b01, 8'h00, "rst_status");
      do_read(2'b00, 8'h00, "rst_data");
      send_frame(8'hC3, 1'b1);
      do_read(2'b01, 8'h01, "hC3_status");
      do_read(2'b00, 8'hC3, "hC3_data");

      wait_clks(2);
      done = 1'b1;
      @(negedge clk);
      #1;
      done = 1'b0;
      wait_clks(1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
